instr_encoder: RTL and testbench

Sequential instruction packer and program loader, the write-side counterpart of the ID stage's field extraction. It accepts decoded fields over a valid/ready handshake, packs them into the 32-bit ASIP instruction format and queues them in a small FIFO. It then writes them into instruction memory at consecutive addresses using a we/ack handshake. It is used by the host/boot path to load RSA decryption programs.

---
 rtl/instr_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded instruction fields into 32-bit ASIP words, buffers
//            them in a small FIFO and writes them to instruction memory at
//            consecutive addresses over a we/ack handshake.
// Option   : define INSTR_ENCODER_CHECKSUM_EN to enable the XOR checksum.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
  parameter int N     = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [1:0]    in_fmt,
  input  logic [2:0]    in_op,
  input  logic [4:0]    in_rf,
  input  logic [4:0]    in_ra,
  input  logic [4:0]    in_rb,
  input  logic [1:0]    in_func,
  input  logic [28:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wd,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic [N-1:0]  checksum
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [1:0]  FMT_R     = 2'b00;
  localparam logic [1:0]  FMT_I     = 2'b01;
  localparam logic [1:0]  FMT_J     = 2'b10;
  localparam logic [1:0]  FMT_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   count_q;
  logic          err_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [N-1:0]  mem_wd_q;
  logic          done_q;

  logic [N-1:0]  fifo_q [DEPTH];
  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic [PW:0]   wr_ptr_d;
  logic [PW:0]   rd_ptr_d;

  logic [N-1:0]  w_packed;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_ack;
  logic          w_start;
  logic          w_writer_on;

  always_comb begin
    w_packed        = '0;
    w_packed[31:29] = in_op;
    case (in_fmt)
      FMT_R: begin
        w_packed[28:24] = in_rf;
        w_packed[23:19] = in_ra;
        w_packed[18:14] = in_rb;
        w_packed[1:0]   = in_func;
      end
      FMT_I: begin
        w_packed[28:24] = in_rf;
        w_packed[23:19] = in_ra;
        w_packed[13:0]  = in_imm[13:0];
      end
      FMT_J: begin
        w_packed[28:0] = in_imm;
      end
      default: begin
        w_packed = '0;
      end
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign w_fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign in_ready    = (state_q == S_RUN) && !w_fifo_full;
  assign w_accept    = in_valid && in_ready;
  assign w_push      = w_accept && (in_fmt != FMT_ILL);
  assign w_writer_on = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign w_pop       = w_writer_on && !mem_we_q && !w_fifo_empty;
  assign w_ack       = mem_we_q && mem_ack;
  assign w_start     = (state_q == S_IDLE) && start;

  assign wr_ptr_d = w_push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = w_pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= w_packed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            ptr_q   <= base_addr;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept && in_last) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_fifo_empty && !mem_we_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (w_accept && (in_fmt == FMT_ILL)) begin
        err_q <= 1'b1;
      end

      // A pop needs mem_we low and an ack needs it high, so they never collide.
      if (w_pop) begin
        mem_we_q   <= 1'b1;
        mem_addr_q <= ptr_q;
        mem_wd_q   <= fifo_q[rd_ptr_q[PW-1:0]];
      end else if (w_ack) begin
        mem_we_q <= 1'b0;
        ptr_q    <= ptr_q + AW'(1);
        if (count_q != COUNT_MAX) begin
          count_q <= count_q + (AW+1)'(1);
        end
      end
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [N-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (w_start) begin
      checksum_q <= '0;
    end else if (w_ack) begin
      checksum_q <= checksum_q ^ mem_wd_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wd      = mem_wd_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign count       = count_q;
  assign err_illegal = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder: packing table, directed
//            corner cases and randomized sessions against a reference model.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int AW    = 10;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [1:0]    in_fmt;
  logic [2:0]    in_op;
  logic [4:0]    in_rf;
  logic [4:0]    in_ra;
  logic [4:0]    in_rb;
  logic [1:0]    in_func;
  logic [28:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wd;
  logic          mem_ack;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err_illegal;
  logic [N-1:0]  checksum;

  instr_encoder #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_fmt     (in_fmt),
    .in_op      (in_op),
    .in_rf      (in_rf),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_func    (in_func),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err_illegal(err_illegal),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  op;
    logic [4:0]  rf;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [1:0]  func;
    logic [28:0] imm;
    logic        last;
    logic [31:0] word;
  } beat_t;

  int n_checks = 0;
  int n_errors = 0;

  beat_t         beats[$];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr;
  int            exp_count;
  bit            exp_err;
  logic [31:0]   exp_cks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Reference packing straight from the field layout, using plain arithmetic.
  function automatic logic [31:0] ref_pack(input beat_t b);
    longint unsigned w;
    w = longint'(b.op) * 64'd536870912;
    case (b.fmt)
      2'd0: w += longint'(b.rf) * 64'd16777216 + longint'(b.ra) * 64'd524288 +
                 longint'(b.rb) * 64'd16384 + longint'(b.func);
      2'd1: w += longint'(b.rf) * 64'd16777216 + longint'(b.ra) * 64'd524288 +
                 longint'(b.imm) % 64'd16384;
      default: w += longint'(b.imm);
    endcase
    return w[31:0];
  endfunction

  function automatic beat_t mk(input int fmt, input int op, input int rf, input int ra,
                               input int rb, input int func, input int imm, input bit last);
    beat_t b;
    b.fmt  = 2'(fmt);
    b.op   = 3'(op);
    b.rf   = 5'(rf);
    b.ra   = 5'(ra);
    b.rb   = 5'(rb);
    b.func = 2'(func);
    b.imm  = 29'(imm);
    b.last = last;
    b.word = ref_pack(b);
    return b;
  endfunction

  function automatic logic [31:0] exp_checksum();
`ifdef INSTR_ENCODER_CHECKSUM_EN
    return exp_cks;
`else
    return 32'h0;
`endif
  endfunction

  // Called at a negedge with inputs set; observes the coming edge's write ack.
  task automatic tick();
    logic          hold;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_wd;
    logic [31:0]   w;
    hold = 1'b0;
    if (mem_we && mem_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {32'h0, mem_wd}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(exp_addr));
        chk("write_data", 64'(mem_wd), 64'(w));
        exp_addr  = exp_addr + AW'(1);
        exp_count = (exp_count < (1 << AW)) ? exp_count + 1 : exp_count;
        exp_cks   = exp_cks ^ w;
      end
    end else if (mem_we) begin
      hold   = 1'b1;
      h_addr = mem_addr;
      h_wd   = mem_wd;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("hold_we", 64'(mem_we), 64'd1);
      chk("hold_addr", 64'(mem_addr), 64'(h_addr));
      chk("hold_wd", 64'(mem_wd), 64'(h_wd));
    end
  endtask

  task automatic drive_beat(input beat_t b);
    in_fmt  = b.fmt;
    in_op   = b.op;
    in_rf   = b.rf;
    in_ra   = b.ra;
    in_rb   = b.rb;
    in_func = b.func;
    in_imm  = b.imm;
    in_last = b.last;
  endtask

  task automatic run_session(input logic [AW-1:0] base, input int ack_pct,
                             input int valid_pct, input int stall, input int spurious_start,
                             input int max_cycles);
    int bi;
    int cyc;
    int accepted;
    bit seen_done;
    exp_q.delete();
    exp_addr  = base;
    exp_count = 0;
    exp_err   = 1'b0;
    exp_cks   = '0;
    start     = 1'b1;
    base_addr = base;
    in_valid  = 1'b0;
    mem_ack   = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_count", 64'(count), 64'd0);
    chk("start_err", 64'(err_illegal), 64'd0);
    chk("start_cks", 64'(checksum), 64'd0);
    bi = 0;
    cyc = 0;
    accepted = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < max_cycles) begin
      if (stall > 0 && cyc == stall) begin
        // Four words fit in the FIFO plus one held in the write register.
        chk("stall_accepted", 64'(accepted), 64'(DEPTH + 1));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (bi < beats.size()) begin
        drive_beat(beats[bi]);
        in_valid = (cyc < stall) || ($urandom_range(99) < valid_pct);
      end else begin
        in_valid = 1'b0;
      end
      mem_ack = (cyc >= stall) && ($urandom_range(99) < ack_pct);
      start = (spurious_start != 0) && ($urandom_range(19) == 0);
      base_addr = AW'($urandom);
      if (in_valid && in_ready) begin
        if (beats[bi].fmt == 2'b11) exp_err = 1'b1;
        else exp_q.push_back(beats[bi].word);
        bi++;
        accepted++;
      end
      tick();
      start = 1'b0;
      cyc++;
      if (done) seen_done = 1'b1;
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    if (!seen_done) begin
      fail_now("session_done");
    end else begin
      chk("done_beats_used", 64'(bi), 64'(beats.size()));
      chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("done_count", 64'(count), 64'(exp_count));
      chk("done_err", 64'(err_illegal), 64'(exp_err));
      chk("done_cks", 64'(checksum), 64'(exp_checksum()));
      chk("done_mem_we", 64'(mem_we), 64'd0);
      tick();
      chk("done_pulse_width", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_ready", 64'(in_ready), 64'd0);
      chk("idle_count_hold", 64'(count), 64'(exp_count));
    end
  endtask

  beat_t vec[6];

  initial begin
    vec[0] = mk(0, 2, 3, 5, 7, 1, 0, 0);                  vec[0].word = 32'h4329C001;
    vec[1] = mk(1, 1, 1, 2, 0, 0, 32'h3FFF, 0);           vec[1].word = 32'h21103FFF;
    vec[2] = mk(2, 7, 0, 0, 0, 0, 32'hABCDEF, 0);         vec[2].word = 32'hE0ABCDEF;
    vec[3] = mk(1, 3, 31, 31, 31, 3, 32'h1FFFFFFF, 0);    vec[3].word = 32'h7FF83FFF;
    vec[4] = mk(0, 5, 0, 31, 0, 3, 32'h1FFFFFFF, 0);      vec[4].word = 32'hA0F80003;
    vec[5] = mk(2, 0, 31, 31, 31, 3, 32'h1FFFFFFF, 1);    vec[5].word = 32'h1FFFFFFF;

    reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_fmt = '0; in_op = '0; in_rf = '0; in_ra = '0; in_rb = '0; in_func = '0;
    in_imm = '0; mem_ack = 1'b0;
    exp_q.delete(); exp_addr = '0; exp_count = 0; exp_err = 1'b0; exp_cks = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wd", 64'(mem_wd), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_cks", 64'(checksum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_ready", 64'(in_ready), 64'd0);
      chk("idle_no_write", 64'(mem_we), 64'd0);
    end
    in_valid = 1'b0;

    // Packing table: one session, each vector written in order.
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(vec[i]);
    run_session(10'h010, 100, 100, 0, 0, 200);

    // Two-format program with known checksum.
    beats.delete();
    beats.push_back(vec[1]);
    beats.push_back(mk(2, 7, 0, 0, 0, 0, 32'hABCDEF, 1));
    run_session(10'h000, 100, 100, 0, 0, 100);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("fmt_checksum", 64'(checksum), 64'h0000_0000_C1BB_F210);
`else
    chk("fmt_checksum", 64'(checksum), 64'h0);
`endif
    chk("fmt_count", 64'(count), 64'd2);

    // Backpressure: no ack for 20 cycles while six beats are offered.
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(mk(0, i, i, i + 1, i + 2, i % 4, 0, i == 5));
    run_session(10'h100, 100, 100, 20, 0, 300);
    chk("bp_count", 64'(count), 64'd6);

    // Illegal beat is consumed but not written.
    beats.delete();
    beats.push_back(mk(3, 1, 1, 1, 1, 1, 1, 0));
    beats.push_back(mk(0, 2, 3, 5, 7, 1, 0, 1));
    run_session(10'h020, 100, 100, 0, 0, 100);
    chk("ill_err", 64'(err_illegal), 64'd1);
    chk("ill_count", 64'(count), 64'd1);

    // Address wrap from the top of memory.
    beats.delete();
    beats.push_back(mk(2, 1, 0, 0, 0, 0, 32'h111, 0));
    beats.push_back(mk(2, 2, 0, 0, 0, 0, 32'h222, 1));
    run_session(10'h3FF, 100, 100, 0, 0, 100);
    chk("wrap_count", 64'(count), 64'd2);

    // Reset while a write is outstanding.
    exp_q.delete();
    start = 1'b1; base_addr = 10'h055; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    drive_beat(mk(0, 1, 1, 1, 1, 1, 0, 1));
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !mem_we; i++) begin
      tick();
      in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (!mem_we) begin
      fail_now("midwrite_we");
    end else begin
      #2 reset = 1'b0;
      #1;
      chk("midrst_mem_we", 64'(mem_we), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_addr", 64'(mem_addr), 64'd0);
      chk("midrst_err", 64'(err_illegal), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    beats.delete();
    beats.push_back(mk(1, 6, 9, 10, 0, 0, 32'h1234, 1));
    run_session(10'h200, 100, 100, 0, 0, 100);
    chk("post_rst_count", 64'(count), 64'd1);

    // Randomized programs with random backpressure and ignored start pulses.
    for (int s = 0; s < 20; s++) begin
      int nb;
      nb = $urandom_range(12, 1);
      beats.delete();
      for (int i = 0; i < nb; i++) begin
        int f;
        f = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
        beats.push_back(mk(f, $urandom, $urandom, $urandom, $urandom, $urandom,
                           $urandom, i == nb - 1));
      end
      run_session(AW'($urandom), $urandom_range(100, 30), $urandom_range(100, 50),
                  0, 1, 2000);
    end

    // Count saturates at 2^AW after more than 2^AW writes.
    beats.delete();
    for (int i = 0; i < (1 << AW) + 1; i++) begin
      beats.push_back(mk(2, $urandom, 0, 0, 0, 0, $urandom, i == (1 << AW)));
    end
    run_session(10'h005, 100, 100, 0, 0, 6000);
    chk("sat_count", 64'(count), 64'(1 << AW));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
